// File: rtl/bram_ctrl_pkg.sv
// Shared constants and encodings for the 256x16 BRAM arbiter.
package bram_ctrl_pkg;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 256;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/bram_arbiter_if.sv
// Two-requester request/response bus between user logic and the BRAM arbiter.
interface bram_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
);

    logic            init_done;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [2*DW-1:0] req_wmask;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;

    modport master (
        input  init_done, req_ready, rsp_valid, rsp_rdata,
        output req_valid, req_we, req_addr, req_wdata, req_wmask
    );

    modport slave (
        output init_done, req_ready, rsp_valid, rsp_rdata,
        input  req_valid, req_we, req_addr, req_wdata, req_wmask
    );

endinterface

// File: rtl/bram_256x16.sv
// 256x16 simple dual-port RAM with SB_RAM40_4K mode-0 behaviour: registered read,
// per-bit active-low write mask, read-during-write returns the old word.
module bram_256x16
    import bram_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] wmask_n,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Clock enables of the primitive are permanently on, so only we/re gate access.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= (mem[waddr] & wmask_n) | (wdata & ~wmask_n);
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Clears the BRAM after reset, then arbitrates two requesters round-robin,
// pairing one read and one write per cycle on the separate RAM ports.
module bram_arbiter
    import bram_ctrl_pkg::*;
#(
    parameter bit            CLEAR_ON_RESET = 1'b1,
    parameter logic [DW-1:0] INIT_VAL       = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    bram_arbiter_if.slave bus
);

    state_e        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          init_done_q;
    logic [1:0]    rsp_valid_q, rsp_valid_d;

    logic [1:0]    grant;
    logic [1:0]    accept;
    logic          contested;

    logic          ram_we, ram_re;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [DW-1:0] ram_wdata, ram_wmask_n, ram_rdata;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear walks 0..255 once, then RUN forever
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            ST_CLEAR: begin
                if (&clr_addr_q) begin
                    state_d = ST_RUN;
                end else begin
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end
            ST_RUN: ;
        endcase
    end

    always_comb begin
        grant     = 2'b00;
        contested = 1'b0;
        if (init_done_q) begin
            if (&bus.req_valid) begin
                if (bus.req_we[0] != bus.req_we[1]) begin
                    grant = 2'b11;
                end else begin
                    contested = 1'b1;
                    grant     = (rr_ptr_q == REQ0) ? 2'b01 : 2'b10;
                end
            end else begin
                grant = bus.req_valid;
            end
        end
    end

    assign accept   = bus.req_valid & grant;
    assign rr_ptr_d = contested ? ~rr_ptr_q : rr_ptr_q;

    // Outputs: RAM port muxes; arbitration guarantees at most one writer and one reader
    always_comb begin
        ram_we      = 1'b0;
        ram_waddr   = '0;
        ram_wdata   = '0;
        ram_wmask_n = '1;
        ram_re      = 1'b0;
        ram_raddr   = '0;
        rsp_valid_d = 2'b00;
        if (state_q == ST_CLEAR) begin
            ram_we      = 1'b1;
            ram_waddr   = clr_addr_q;
            ram_wdata   = INIT_VAL;
            ram_wmask_n = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (accept[i] && bus.req_we[i]) begin
                    ram_we      = 1'b1;
                    ram_waddr   = bus.req_addr[i*AW +: AW];
                    ram_wdata   = bus.req_wdata[i*DW +: DW];
                    ram_wmask_n = ~bus.req_wmask[i*DW +: DW];
                end
                if (accept[i] && !bus.req_we[i]) begin
                    ram_re         = 1'b1;
                    ram_raddr      = bus.req_addr[i*AW +: AW];
                    rsp_valid_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_addr_q  <= '0;
            rr_ptr_q    <= REQ0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 2'b00;
        end else begin
            clr_addr_q  <= clr_addr_d;
            rr_ptr_q    <= rr_ptr_d;
            init_done_q <= (state_q == ST_RUN);
            rsp_valid_q <= rsp_valid_d;
        end
    end

    bram_256x16 u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .wmask_n (ram_wmask_n),
        .re      (ram_re),
        .raddr   (ram_raddr),
        .rdata   (ram_rdata)
    );

    assign bus.init_done = init_done_q;
    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    // RAM output register is not reset; mask it outside response cycles
    assign bus.rsp_rdata = (|rsp_valid_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: clear, masked writes, round-robin, paired ports, reset.
module tb_bram_arbiter;

    logic clk;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    bram_arbiter_if bus ();
    bram_arbiter_if bus2 ();

    bram_arbiter #(
        .CLEAR_ON_RESET (1'b1),
        .INIT_VAL       (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    bram_arbiter #(
        .CLEAR_ON_RESET (1'b0),
        .INIT_VAL       (16'h0000)
    ) dut_noclr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input bit we, input logic [7:0] addr,
                           input logic [15:0] wdata, input logic [15:0] wmask);
        bus.req_valid[id]         = 1'b1;
        bus.req_we[id]            = we;
        bus.req_addr[id*8 +: 8]   = addr;
        bus.req_wdata[id*16 +: 16] = wdata;
        bus.req_wmask[id*16 +: 16] = wmask;
    endtask

    task automatic clr_req(input int id);
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic do_write(input int id, input logic [7:0] addr, input logic [15:0] wdata,
                            input logic [15:0] wmask, input string tag);
        set_req(id, 1'b1, addr, wdata, wmask);
        #1;
        chk({tag, "_ready"}, 32'(bus.req_ready[id]), 32'd1);
        @(posedge clk);
        #1;
        clr_req(id);
    endtask

    task automatic do_read(input int id, input logic [7:0] addr, input logic [15:0] exp,
                           input string tag);
        set_req(id, 1'b0, addr, 16'h0, 16'h0);
        #1;
        chk({tag, "_ready"}, 32'(bus.req_ready[id]), 32'd1);
        @(posedge clk);
        #1;
        clr_req(id);
        chk({tag, "_vld"}, 32'(bus.rsp_valid), 32'd1 << id);
        chk({tag, "_data"}, 32'(bus.rsp_rdata), 32'(exp));
    endtask

    // Release reset on a falling edge and count rising edges until init_done.
    task automatic release_and_wait(input string tag, input bit check_noclr);
        int cycles;
        cycles = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        if (check_noclr) chk("noclr_init_before_edge", 32'(bus2.init_done), 32'd0);
        while (cycles < 400) begin
            @(posedge clk);
            #1;
            cycles++;
            if (check_noclr && cycles == 1) chk("noclr_init_first_edge", 32'(bus2.init_done), 32'd1);
            if (cycles == 100) begin
                chk({tag, "_ready_in_clear"}, 32'(bus.req_ready), 32'd0);
                bus.req_valid = 2'b00;
            end
            if (bus.init_done) break;
        end
        chk({tag, "_init_cycles"}, 32'(cycles), 32'd257);
    endtask

    initial begin
        int          n0, n1, nboth;
        logic [1:0]  exp_g;
        logic [15:0] exp_d;

        rst_n         = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_we    = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        bus2.req_valid = 2'b00;
        bus2.req_we    = 2'b00;
        bus2.req_addr  = '0;
        bus2.req_wdata = '0;
        bus2.req_wmask = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_init_done", 32'(bus.init_done), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);

        // 1: clear sequence and cleared contents
        release_and_wait("clr1", 1'b1);
        bus.req_valid = 2'b00;
        chk("clr1_ready_after", 32'(bus.req_ready), 32'd0);
        do_read(0, 8'h00, 16'h0000, "clr_rd00");
        do_read(0, 8'h7F, 16'h0000, "clr_rd7f");
        do_read(1, 8'hFF, 16'h0000, "clr_rdff");

        // 2, 3: full and masked writes
        do_write(0, 8'h12, 16'hBEEF, 16'hFFFF, "t2_wr");
        do_read(0, 8'h12, 16'hBEEF, "t2_rd");
        do_write(1, 8'h12, 16'h1234, 16'h00FF, "t3_wr");
        do_read(1, 8'h12, 16'hBE34, "t3_rd");

        // 4: contested reads alternate, starting with requester 0
        do_write(0, 8'h01, 16'h1111, 16'hFFFF, "t4_wr1");
        do_write(1, 8'h02, 16'h2222, 16'hFFFF, "t4_wr2");
        set_req(0, 1'b0, 8'h01, 16'h0, 16'h0);
        set_req(1, 1'b0, 8'h02, 16'h0, 16'h0);
        n0 = 0;
        n1 = 0;
        nboth = 0;
        for (int k = 0; k < 8; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (k % 2 == 0) ? 16'h1111 : 16'h2222;
            #1;
            chk("t4_ready", 32'(bus.req_ready), 32'(exp_g));
            @(posedge clk);
            #1;
            chk("t4_rsp_valid", 32'(bus.rsp_valid), 32'(exp_g));
            chk("t4_rdata", 32'(bus.rsp_rdata), 32'(exp_d));
            if (bus.rsp_valid == 2'b01) n0++;
            if (bus.rsp_valid == 2'b10) n1++;
            if (bus.rsp_valid == 2'b11) nboth++;
        end
        bus.req_valid = 2'b00;
        chk("t4_count0", 32'(n0), 32'd4);
        chk("t4_count1", 32'(n1), 32'd4);
        chk("t4_both", 32'(nboth), 32'd0);
        @(posedge clk);
        #1;
        chk("t4_idle_rsp", 32'(bus.rsp_valid), 32'd0);

        // 5: paired write and read to the same address
        set_req(0, 1'b1, 8'h20, 16'hAAAA, 16'hFFFF);
        set_req(1, 1'b0, 8'h20, 16'h0, 16'h0);
        #1;
        chk("t5_ready", 32'(bus.req_ready), 32'd3);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'd2);
        chk("t5_old_data", 32'(bus.rsp_rdata), 32'h0000);
        do_read(0, 8'h20, 16'hAAAA, "t5_new");

        // Contested writes: requester 0 first, then requester 1
        set_req(0, 1'b1, 8'h30, 16'h3030, 16'hFFFF);
        set_req(1, 1'b1, 8'h31, 16'h3131, 16'hFFFF);
        #1;
        chk("cw_ready_first", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("cw_ready_second", 32'(bus.req_ready), 32'd2);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        do_read(1, 8'h30, 16'h3030, "cw_rd30");
        do_read(0, 8'h31, 16'h3131, "cw_rd31");

        // 6: reset right after a read accept drops the response and reruns the clear
        set_req(0, 1'b0, 8'h12, 16'h0, 16'h0);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("t6_rsp_dropped", 32'(bus.rsp_valid), 32'd0);
        chk("t6_init_low", 32'(bus.init_done), 32'd0);
        chk("t6_ready_low", 32'(bus.req_ready), 32'd0);
        repeat (2) @(posedge clk);
        release_and_wait("clr2", 1'b0);
        do_read(0, 8'h12, 16'h0000, "t6_recleared");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
